// File: rtl/xbox_xmem_resp_if.sv
// Bundle of accelerator-side and SOC-side memory signals for xbox_xmem_resp.
// SOC handshake: soc_req acts as valid and soc_gnt as ready; the word access
// takes place in the cycle where both are high. The requester holds soc_req
// and its attributes stable until that cycle. soc_gnt may depend
// combinationally on soc_req in the same cycle.
interface xbox_xmem_resp_if #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 4
);
  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_wdata;
  logic [NUM_MEMS-1:0][31:0]                   xlr_mem_be;
  logic [NUM_MEMS-1:0]                         xlr_mem_rd;
  logic [NUM_MEMS-1:0]                         xlr_mem_wr;
  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_rdata;

  logic        soc_req;
  logic        soc_we;
  logic [18:0] soc_addr;
  logic [31:0] soc_wdata;
  logic [3:0]  soc_be;
  logic        soc_gnt;
  logic        soc_rvalid;
  logic [31:0] soc_rdata;
  logic        trig_soc_xmem_wr;
  logic [18:0] trig_soc_xmem_wr_addr;
  logic [15:0] soc_stall_cnt;

  modport master (
    output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    input  xlr_mem_rdata,
    output soc_req, soc_we, soc_addr, soc_wdata, soc_be,
    input  soc_gnt, soc_rvalid, soc_rdata,
    input  trig_soc_xmem_wr, trig_soc_xmem_wr_addr, soc_stall_cnt
  );

  modport slave (
    input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    output xlr_mem_rdata,
    input  soc_req, soc_we, soc_addr, soc_wdata, soc_be,
    output soc_gnt, soc_rvalid, soc_rdata,
    output trig_soc_xmem_wr, trig_soc_xmem_wr_addr, soc_stall_cnt
  );
endinterface

// File: rtl/xbox_xmem_resp.sv
// Flop-based XBOX line memory shared between an accelerator (one line port
// per bank, absolute priority) and a SOC word port that is stalled only when
// it collides with accelerator activity on the same bank.
module xbox_xmem_resp #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int SPACE_SIZE_PER_MEM = 1024
) (
  input  logic       clk,
  input  logic       rst,
  xbox_xmem_resp_if.slave bus
);
  localparam int LINES = 1 << LOG2_LINES_PER_MEM;
  // Lines beyond the reserved SOC window of a bank cannot be reached.
  localparam int LINES_VISIBLE = (LINES < SPACE_SIZE_PER_MEM) ? LINES : SPACE_SIZE_PER_MEM;
  localparam int BANK_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

  logic [NUM_MEMS-1:0][LINES-1:0][7:0][31:0] mem;

  logic [3:0]                    soc_bank;
  logic [9:0]                    soc_line;
  logic [2:0]                    soc_word;
  logic [BANK_W-1:0]             soc_bank_idx;
  logic [LOG2_LINES_PER_MEM-1:0] soc_line_idx;
  logic [NUM_MEMS-1:0]           xlr_busy;
  logic                          soc_in_range;
  logic                          soc_conflict;
  logic                          soc_deny;
  logic                          soc_wr_go;
  logic                          soc_rd_go;

  // Decode the SOC address and arbitrate against the accelerator. An
  // out-of-range access touches no storage, so it never conflicts.
  always_comb begin
    soc_bank     = bus.soc_addr[18:15];
    soc_line     = bus.soc_addr[14:5];
    soc_word     = bus.soc_addr[4:2];
    soc_bank_idx = BANK_W'(soc_bank);
    soc_line_idx = LOG2_LINES_PER_MEM'(soc_line);
    soc_in_range = (int'(soc_bank) < NUM_MEMS) && (int'(soc_line) < LINES_VISIBLE);
    xlr_busy     = bus.xlr_mem_rd | bus.xlr_mem_wr;
    soc_conflict = soc_in_range && xlr_busy[soc_bank_idx];
    bus.soc_gnt  = bus.soc_req && !soc_conflict;
    soc_deny     = bus.soc_req && soc_conflict;
    soc_wr_go    = bus.soc_req && !soc_conflict && bus.soc_we;
    soc_rd_go    = bus.soc_req && !soc_conflict && !bus.soc_we;
  end

  // Storage update: accelerator byte writes per bank, then the granted SOC
  // word write (never on a bank the accelerator is using this cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int b = 0; b < NUM_MEMS; b++) begin
        if (bus.xlr_mem_wr[b]) begin
          for (int i = 0; i < 32; i++) begin
            if (bus.xlr_mem_be[b][i]) begin
              mem[b][bus.xlr_mem_addr[b]][i/4][(i%4)*8 +: 8] <= bus.xlr_mem_wdata[b][i/4][(i%4)*8 +: 8];
            end
          end
        end
      end
      if (soc_wr_go && soc_in_range) begin
        for (int j = 0; j < 4; j++) begin
          if (bus.soc_be[j]) begin
            mem[soc_bank_idx][soc_line_idx][soc_word][j*8 +: 8] <= bus.soc_wdata[j*8 +: 8];
          end
        end
      end
    end
  end

  // Registered read data, SOC completion pulses and the stall counter. Reads
  // sample mem before this edge's writes land, giving old data on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.xlr_mem_rdata         <= '0;
      bus.soc_rvalid            <= 1'b0;
      bus.soc_rdata             <= '0;
      bus.trig_soc_xmem_wr      <= 1'b0;
      bus.trig_soc_xmem_wr_addr <= '0;
      bus.soc_stall_cnt         <= '0;
    end else begin
      for (int b = 0; b < NUM_MEMS; b++) begin
        if (bus.xlr_mem_rd[b]) begin
          bus.xlr_mem_rdata[b] <= mem[b][bus.xlr_mem_addr[b]];
        end
      end
      bus.soc_rvalid <= soc_rd_go;
      if (soc_rd_go) begin
        bus.soc_rdata <= soc_in_range ? mem[soc_bank_idx][soc_line_idx][soc_word] : 32'h0;
      end
      bus.trig_soc_xmem_wr <= soc_wr_go;
      if (soc_wr_go) begin
        bus.trig_soc_xmem_wr_addr <= bus.soc_addr;
      end
      if (soc_deny && (bus.soc_stall_cnt != 16'hFFFF)) begin
        bus.soc_stall_cnt <= bus.soc_stall_cnt + 16'd1;
      end
    end
  end
endmodule
